// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential packed-BCD to binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } b2b_state_t;

  localparam int BCD_DIGIT_W = 4;

  function automatic logic bcd_nibble_ok(input logic [BCD_DIGIT_W-1:0] nib);
    return (nib <= BCD_DIGIT_W'(9));
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for reverse double-dabble: a digit that picked up a
// carried-in 8 from its upper neighbour must only gain 5, so subtract 3.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= BCD_DIGIT_W'(8)) ? (digit_i - BCD_DIGIT_W'(3)) : digit_i;

endmodule

// File: rtl/bcd2bin_seq.sv
// Packed-BCD to binary converter, one right shift per clock with a
// start/busy/done handshake.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int BIN_W  = 27
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          busy,
  output logic                          done,
  output logic [BIN_W-1:0]              bin_out,
  output logic                          err
);

  localparam int W     = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W - 1);

  localparam logic [64:0] MAX_DEC   = {1'b0, (64'd10 ** DIGITS) - 64'd1};
  localparam logic [64:0] BIN_RANGE = 65'd1 << BIN_W;

  generate
    if (DIGITS < 1 || DIGITS > 8 || BIN_W > W || BIN_RANGE <= MAX_DEC) begin : g_param_err
      $error("bcd2bin_seq: DIGITS must be 1..8 and BIN_W must hold 10**DIGITS-1 within 4*DIGITS bits");
    end
  endgenerate

  b2b_state_t       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W-1:0]     bcd_q, bin_q;
  logic [W-1:0]     bcd_sh, bin_sh, bcd_adj;
  logic [CNT_W-1:0] cnt_q;
  logic [BIN_W-1:0] bin_out_q;
  logic             err_q;
  logic             accept;
  logic             bad_digit;
  logic             last_shift;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_nibble_ok(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) bad_digit = 1'b1;
    end
  end

  assign accept     = (state_q == IDLE) && start;
  assign last_shift = (state_q == SHIFT) && (cnt_q == '0);

  // BCD LSB falls into the BIN MSB; the digits are corrected after the shift.
  assign {bcd_sh, bin_sh} = {bcd_q, bin_q} >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (bcd_sh [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // NOTE: defaults first in combinational blocks, so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = bad_digit ? DONE : SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // NOTE: the shift registers are reset too; they are small and it keeps an aborted job from leaking X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      bcd_q <= bcd_in;
      bin_q <= '0;
      cnt_q <= CNT_LOAD;
      err_q <= bad_digit;
      if (bad_digit) bin_out_q <= '0;
    end else if (state_q == SHIFT) begin
      bcd_q <= bcd_adj;
      bin_q <= bin_sh;
      cnt_q <= cnt_q - CNT_W'(1);
      if (last_shift) bin_out_q <= bin_sh[BIN_W-1:0];
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bin_out = bin_out_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed and random bench for bcd2bin_seq at its default 8-digit size.
module tb_bcd2bin_seq;

  localparam int BUDGET = 100;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] bcd_in;
  logic        busy;
  logic        done;
  logic [26:0] bin_out;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  bcd2bin_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [26:0] bcd_ref(input logic [31:0] v);
    int unsigned acc = 0;
    for (int i = 7; i >= 0; i--) acc = acc * 10 + int'(v[i*4 +: 4]);
    return acc[26:0];
  endfunction

  // Launch one job and wait (bounded) for done; lat counts edges after E0.
  task automatic run_job(input logic [31:0] v, output int lat, output bit busy_seen,
                         output bit overlap, output bit done_next);
    @(posedge clk); #1;
    bcd_in = v;
    start  = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    bcd_in    = 32'hFFFF_FFFF;
    lat       = 0;
    busy_seen = busy;
    overlap   = busy && done;
    while (!done && lat < BUDGET) begin
      @(posedge clk); #1;
      lat++;
      busy_seen |= busy;
      overlap   |= busy && done;
    end
    @(posedge clk); #1;
    done_next = done;
    overlap  |= busy && done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bcd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got busy/done/err=%b required 000", {busy, done, err});
    end
    n_checks++;
    if (bin_out !== 27'h0) begin
      n_fail++; $display("FAIL reset_bin: got %h required 0", bin_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; bit bs, ov, dn;
    run_job(32'h0018_4135, lat, bs, ov, dn);
    n_checks++;
    if (lat !== 32) begin
      n_fail++; $display("FAIL basic_latency: got %0d required 32", lat);
    end
    n_checks++;
    if (bin_out !== 27'h2CF47) begin
      n_fail++; $display("FAIL basic_bin: got %h required 2cf47", bin_out);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL basic_err: got %b required 0", err);
    end
    n_checks++;
    if (bs !== 1'b1 || ov !== 1'b0 || dn !== 1'b0) begin
      n_fail++; $display("FAIL basic_handshake: got busy_seen=%b overlap=%b done_next=%b required 1 0 0", bs, ov, dn);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] vin  [3] = '{32'h9999_9999, 32'h0000_0000, 32'h0000_0010};
    logic [26:0] vexp [3] = '{27'h5F5E0FF, 27'h0, 27'hA};
    int lat; bit bs, ov, dn;
    for (int i = 0; i < 3; i++) begin
      run_job(vin[i], lat, bs, ov, dn);
      n_checks++;
      if (bin_out !== vexp[i] || err !== 1'b0 || lat !== 32) begin
        n_fail++;
        $display("FAIL vector_%0d: got bin=%h err=%b lat=%0d required bin=%h err=0 lat=32",
                 i, bin_out, err, lat, vexp[i]);
      end
    end
  endtask

  task automatic test_invalid();
    logic [31:0] vin [2] = '{32'h0000_001A, 32'hF000_0000};
    int lat; bit bs, ov, dn;
    for (int i = 0; i < 2; i++) begin
      run_job(vin[i], lat, bs, ov, dn);
      n_checks++;
      if (lat !== 0 || err !== 1'b1 || bin_out !== 27'h0) begin
        n_fail++;
        $display("FAIL invalid_%0d: got lat=%0d err=%b bin=%h required lat=0 err=1 bin=0", i, lat, err, bin_out);
      end
      n_checks++;
      if (bs !== 1'b0 || dn !== 1'b0) begin
        n_fail++; $display("FAIL invalid_busy_%0d: got busy_seen=%b done_next=%b required 0 0", i, bs, dn);
      end
    end
  endtask

  task automatic test_ignore_start();
    int t = 0, n_done = 0, first_done = -1;
    @(posedge clk); #1;
    bcd_in = 32'h0000_0042; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bcd_in = 32'h0000_0077;
    repeat (3) begin @(posedge clk); #1; t++; end
    start = 1'b1;
    @(posedge clk); #1; t++;
    start = 1'b0;
    while (t < 45) begin
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = t;
      end
      @(posedge clk); #1; t++;
    end
    n_checks++;
    if (n_done !== 1 || first_done !== 32) begin
      n_fail++; $display("FAIL ignore_done: got pulses=%0d at=%0d required 1 at 32", n_done, first_done);
    end
    n_checks++;
    if (bin_out !== 27'h2A) begin
      n_fail++; $display("FAIL ignore_bin: got %h required 2a", bin_out);
    end
  endtask

  task automatic test_async_reset();
    int n_done = 0;
    int lat; bit bs, ov, dn;
    @(posedge clk); #1;
    bcd_in = 32'h0009_8765; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, err} !== 3'b000 || bin_out !== 27'h0) begin
      n_fail++;
      $display("FAIL async_reset: got busy/done/err=%b bin=%h required 000 bin=0", {busy, done, err}, bin_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    n_checks++;
    if (n_done !== 0) begin
      n_fail++; $display("FAIL abort_no_done: got %0d pulses required 0", n_done);
    end
    run_job(32'h0001_2345, lat, bs, ov, dn);
    n_checks++;
    if (bin_out !== 27'h3039 || lat !== 32) begin
      n_fail++; $display("FAIL after_reset: got bin=%h lat=%0d required 3039 lat=32", bin_out, lat);
    end
  endtask

  task automatic test_back_to_back();
    int t1 = -1, t2 = -1, n_done = 0;
    @(posedge clk); #1;
    bcd_in = 32'h0000_0500; start = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        if (t1 < 0) t1 = c;
        else if (t2 < 0) t2 = c;
      end
    end
    n_checks++;
    if (n_done !== 2 || t1 !== 32 || t2 - t1 !== 34) begin
      n_fail++; $display("FAIL b2b_timing: got pulses=%0d t1=%0d t2=%0d required 2 32 66", n_done, t1, t2);
    end
    n_checks++;
    if (bin_out !== 27'h1F4) begin
      n_fail++; $display("FAIL b2b_bin: got %h required 1f4", bin_out);
    end
    start = 1'b0;
    repeat (40) @(posedge clk);
  endtask

  task automatic test_random();
    logic [31:0] v;
    int lat; bit bs, ov, dn;
    for (int n = 0; n < 1000; n++) begin
      for (int d = 0; d < 8; d++) v[d*4 +: 4] = 4'($urandom_range(0, 9));
      run_job(v, lat, bs, ov, dn);
      n_checks++;
      if (bin_out !== bcd_ref(v) || err !== 1'b0) begin
        n_fail++; $display("FAIL rand_bin: in=%h got bin=%h err=%b required bin=%h err=0", v, bin_out, err, bcd_ref(v));
      end
      n_checks++;
      if (lat !== 32) begin
        n_fail++; $display("FAIL rand_latency: in=%h got %0d required 32", v, lat);
      end
      n_checks++;
      if (dn !== 1'b0 || ov !== 1'b0) begin
        n_fail++; $display("FAIL rand_pulse: in=%h got done_next=%b overlap=%b required 0 0", v, dn, ov);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_invalid();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
